uart_rx_8n1: RTL and testbench
==============================

# uart_rx_8n1

Oversampling UART receiver for the iCE40 UART path. It takes the raw `uartrx` pad and decodes 8N1 frames into bytes, replacing the current pad-to-pad loopback with a byte-level stream. Output is a one-entry buffered valid/ready byte interface for a downstream consumer, typically the transmitter in `uart_trx.v` or an LED/debug stage. It runs on the internal oscillator clock (SB_HFOSC, 12 MHz with CLKHF_DIV 0b10).

## Interface
- `CLK_HZ`, 12000000, frequency of `hw_clk` in Hz
- `BAUD`, 9600, line bit rate
- `OVERSAMPLE`, 16, sample ticks per bit; must be even and at least 8

- `hw_clk`  input  1  single clock for all logic, rising edge
- `rst_n`  input  1  reset; asynchronous, active-low
- `uartrx`  input  1  raw serial line, asynchronous to `hw_clk`, idle high
- `rx_data`  output  8  received byte, valid while `rx_valid`=1
- `rx_valid`  output  1  byte held in output register
- `rx_ready`  input  1  consumer accepts the byte on a cycle with `rx_valid`&`rx_ready`
- `rx_busy`  output  1  high from start-bit detection until the frame ends
- `frame_err`  output  1  one-cycle pulse when the stop bit samples low
- `overrun`  output  1  one-cycle pulse when a new byte is dropped because the buffer is full

## Operation
- Synchronizer: 2-flop on `uartrx`, both flops reset to 1. All decisions use the second flop (`rx_s`).
- Tick divider: DIV = (CLK_HZ + BAUD*OVERSAMPLE/2) / (BAUD*OVERSAMPLE), rounded to nearest, with DIV ≥ 2 (elaboration error otherwise).
  - Counter width is $clog2(DIV).
  - Free-running; emits `tick` for one cycle when the count wraps DIV-1→0.
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE: on a `tick` with `rx_s`=0, go to START and clear the sample counter.
  - START: after OVERSAMPLE/2 ticks (mid-bit):
    - `rx_s`=1: false start, return to IDLE with no outputs.
    - `rx_s`=0: go to DATA and reset the bit index to 0.
  - DATA: every OVERSAMPLE ticks, sample `rx_s` into the shift register, LSB first. After bit 7, go to STOP.
  - STOP: after OVERSAMPLE ticks (mid stop bit):
    - `rx_s`=1: deliver the byte and go to IDLE.
    - `rx_s`=0: pulse `frame_err`, discard the byte, go to WAIT_HIGH.
  - WAIT_HIGH: stay until a `tick` with `rx_s`=1, then go to IDLE. This rejects a break condition as a stream of frames.
- Delivery: when `rx_valid`=0, or when `rx_valid`&`rx_ready` in the same cycle, load `rx_data` and set `rx_valid`=1.
  - Otherwise the new byte is dropped, `overrun` pulses, and the old `rx_data` is retained.
- Handshake: `rx_valid` clears on a cycle with `rx_valid`&`rx_ready` and no simultaneous delivery. `rx_data` is stable while `rx_valid`=1 and not accepted.
- `rx_busy` = 1 in START, DATA and STOP.
- Reset (any time, including mid-frame):
  - FSM goes to IDLE; all counters clear.
  - `rx_data`=0, `rx_valid`=0, `rx_busy`=0, `frame_err`=0, `overrun`=0; synchronizer flops go to 1.
  - After reset is released during an active frame, the receiver resynchronizes on the next falling edge.

## Timing
- Synchronizer latency: 2 cycles. Start-detect jitter: up to 1 tick (DIV cycles).
- Sample points relative to start detection:
  - start bit check at OVERSAMPLE/2 ticks;
  - data bit n at OVERSAMPLE/2 + (n+1)*OVERSAMPLE ticks;
  - stop bit at OVERSAMPLE/2 + 9*OVERSAMPLE ticks.
- `rx_valid` rises the cycle after the stop-bit sample tick. `frame_err` and `overrun` pulse in that same cycle.
- The receiver is back in IDLE from mid stop bit, so back-to-back frames with a one-bit stop are received without loss.
- Consumer latency is unbounded. A held byte survives any number of later frames; each later frame produces an `overrun` pulse.
- Simultaneous accept and delivery in one cycle: the new byte loads, `rx_valid` stays 1, no `overrun`.

## Test plan
All scenarios use CLK_HZ=640000, BAUD=10000, OVERSAMPLE=16, giving DIV=4 and a bit time of 64 cycles.
- Single frame: send 0xA5 with `rx_ready`=0 → `rx_valid`=1, `rx_data`=0xA5, no `frame_err`. Assert `rx_ready` for one cycle → `rx_valid`=0 next cycle.
- Back-to-back frames: send 0x00, 0xFF, 0x55 with one stop bit each and `rx_ready`=1 → exactly three accepts in order 0x00, 0xFF, 0x55; `rx_busy` low only between stop-bit mid and next start.
- False start: 20-cycle low glitch on idle line → FSM returns to IDLE, no `rx_valid`, no `frame_err`.
- Framing error and break: frame 0x3C with stop bit low → one `frame_err` pulse, no `rx_valid`. Then hold the line low for 2000 cycles → no further pulses; a clean 0x81 afterwards is received correctly.
- Overrun: send 0x11 then 0x22 with `rx_ready`=0 → `rx_data` stays 0x11 and one `overrun` pulse occurs. A simultaneous accept and delivery on the third frame 0x33 loads 0x33 with no `overrun`.
- Mid-frame reset: assert `rst_n`=0 for 3 cycles during data bit 3 of 0xC3 → all outputs 0 immediately. Next full frame 0x5A is received correctly.

Source files
------------

// File: rtl/uart_rx_8n1.sv
// uart_rx_8n1: oversampling 8N1 UART receiver with a one-entry valid/ready byte buffer
// Ports: hw_clk clock, rst_n async active-low reset, uartrx raw idle-high serial line,
// rx_data/rx_valid/rx_ready buffered byte handshake, rx_busy frame in progress,
// frame_err pulse on a low stop bit, overrun pulse when a byte is dropped on a full buffer.
module uart_rx_8n1 #(
    parameter int CLK_HZ     = 12000000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic       hw_clk,
    input  logic       rst_n,
    input  logic       uartrx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       rx_busy,
    output logic       frame_err,
    output logic       overrun
);
    localparam int DIV = (CLK_HZ + BAUD * OVERSAMPLE / 2) / (BAUD * OVERSAMPLE);
    localparam int DW  = DIV > 1 ? $clog2(DIV) : 1;
    localparam int SW  = $clog2(OVERSAMPLE);

    if (DIV < 2) begin : g_div_chk
        $error("uart_rx_8n1: DIV must be at least 2");
    end
    if (OVERSAMPLE < 8 || OVERSAMPLE % 2 != 0) begin : g_os_chk
        $error("uart_rx_8n1: OVERSAMPLE must be even and at least 8");
    end

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

    state_t        state;
    logic [1:0]    sync;
    logic          rx_s;
    logic [DW-1:0] div_cnt;
    logic          tick;
    logic [SW-1:0] smp_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic          half;
    logic          full;

    assign rx_s = sync[1];
    assign tick = div_cnt == DW'(DIV - 1);
    assign half = smp_cnt == SW'(OVERSAMPLE / 2 - 1);
    assign full = smp_cnt == SW'(OVERSAMPLE - 1);

    always_ff @(posedge hw_clk or negedge rst_n)
        if (!rst_n) sync <= 2'b11;
        else        sync <= {sync[0], uartrx};

    always_ff @(posedge hw_clk or negedge rst_n)
        if (!rst_n) div_cnt <= '0;
        else        div_cnt <= tick ? '0 : div_cnt + 1'b1;

    // smp_cnt free-runs outside a frame; it is cleared on every entry to START
    always_ff @(posedge hw_clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            smp_cnt   <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            rx_busy   <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            if (rx_valid && rx_ready) rx_valid <= 1'b0;
            if (tick) begin
                smp_cnt <= smp_cnt + 1'b1;
                case (state)
                    IDLE: if (!rx_s) begin
                        state   <= START;
                        smp_cnt <= '0;
                        rx_busy <= 1'b1;
                    end
                    START: if (half) begin
                        smp_cnt <= '0;
                        bit_idx <= '0;
                        state   <= rx_s ? IDLE : DATA;
                        rx_busy <= !rx_s;
                    end
                    DATA: if (full) begin
                        smp_cnt <= '0;
                        shift   <= {rx_s, shift[7:1]};
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) state <= STOP;
                    end
                    STOP: if (full) begin
                        smp_cnt <= '0;
                        rx_busy <= 1'b0;
                        if (!rx_s) begin
                            frame_err <= 1'b1;
                            state     <= WAIT_HIGH;
                        end else begin
                            state <= IDLE;
                            // a same-cycle accept frees the buffer for the new byte
                            if (!rx_valid || rx_ready) begin
                                rx_data  <= shift;
                                rx_valid <= 1'b1;
                            end else begin
                                overrun <= 1'b1;
                            end
                        end
                    end
                    WAIT_HIGH: if (rx_s) state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_8n1.sv
// tb_uart_rx_8n1: self-checking bench for uart_rx_8n1 (table vectors, corner sequences, random frames)
`timescale 1ns/1ps
module tb_uart_rx_8n1;
    localparam int CLK_HZ = 640000;
    localparam int BAUD   = 10000;
    localparam int OS     = 16;
    localparam int BIT    = 64;

    typedef struct {
        logic [7:0] d;
        logic       stop;
        logic       ev;
        logic [7:0] ed;
        int         ef;
        int         eo;
        logic       drain;
    } vec_t;

    logic       hw_clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       uartrx = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_busy;
    logic       frame_err;
    logic       overrun;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int ferr_n = 0;
    int ovr_n = 0;
    int ovr_cyc = -1;
    logic [7:0] acc_q[$];
    logic [7:0] exp_q[$];
    vec_t tbl[7];

    uart_rx_8n1 #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(OS)) dut (
        .hw_clk(hw_clk),
        .rst_n(rst_n),
        .uartrx(uartrx),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .rx_ready(rx_ready),
        .rx_busy(rx_busy),
        .frame_err(frame_err),
        .overrun(overrun)
    );

    always #5 hw_clk = ~hw_clk;

    always @(posedge hw_clk or negedge rst_n)
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;

    always @(negedge hw_clk) begin
        if (frame_err) ferr_n++;
        if (overrun) begin
            ovr_n++;
            ovr_cyc = cyc;
        end
        if (rx_valid && rx_ready) acc_q.push_back(rx_data);
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge hw_clk);
            #1;
        end
    endtask

    task automatic align();
        do step(); while (cyc % 4 != 0);
    endtask

    // drives one frame; the line is left at the stop-bit level
    task automatic send(input logic [7:0] d, input logic stop);
        uartrx = 1'b0;
        step(BIT);
        for (int i = 0; i < 8; i++) begin
            uartrx = d[i];
            step(BIT);
        end
        uartrx = stop;
        step(BIT);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic clr();
        ferr_n = 0;
        ovr_n = 0;
        acc_q.delete();
    endtask

    task automatic drain();
        rx_ready = 1'b1;
        step();
        rx_ready = 1'b0;
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int busy_lo;
        int busy_seen;
        int s;
        int d;
        int nbad;
        int ngood;
        logic [7:0] first;
        logic [7:0] b;
        logic st;
        tbl[0] = '{8'hA5, 1'b1, 1'b1, 8'hA5, 0, 0, 1'b1};
        tbl[1] = '{8'h3C, 1'b0, 1'b0, 8'h00, 1, 0, 1'b0};
        tbl[2] = '{8'h81, 1'b1, 1'b1, 8'h81, 0, 0, 1'b1};
        tbl[3] = '{8'h11, 1'b1, 1'b1, 8'h11, 0, 0, 1'b0};
        tbl[4] = '{8'h22, 1'b1, 1'b1, 8'h11, 0, 1, 1'b0};
        tbl[5] = '{8'h44, 1'b0, 1'b1, 8'h11, 1, 0, 1'b0};
        tbl[6] = '{8'h66, 1'b1, 1'b1, 8'h11, 0, 1, 1'b1};

        step(3);
        chk("reset rx_valid", rx_valid, 0);
        chk("reset rx_data", rx_data, 0);
        chk("reset rx_busy", rx_busy, 0);
        rst_n = 1'b1;
        step(4);
        chk("idle frame_err", frame_err, 0);
        chk("idle overrun", overrun, 0);

        for (int i = 0; i < 7; i++) begin
            clr();
            align();
            send(tbl[i].d, tbl[i].stop);
            uartrx = 1'b1;
            step(BIT);
            chk($sformatf("vec%0d rx_valid", i), rx_valid, tbl[i].ev);
            if (tbl[i].ev) chk($sformatf("vec%0d rx_data", i), rx_data, tbl[i].ed);
            chk($sformatf("vec%0d frame_err pulses", i), ferr_n, tbl[i].ef);
            chk($sformatf("vec%0d overrun pulses", i), ovr_n, tbl[i].eo);
            if (tbl[i].drain) begin
                drain();
                chk($sformatf("vec%0d rx_valid after accept", i), rx_valid, 0);
                chk($sformatf("vec%0d accepted byte", i), acc_q.size() == 1 ? int'(acc_q[0]) : -1, tbl[i].ed);
            end
        end

        clr();
        rx_ready = 1'b1;
        busy_lo = 0;
        align();
        fork
            begin
                send(8'h00, 1'b1);
                send(8'hFF, 1'b1);
                send(8'h55, 1'b1);
            end
            for (int i = 0; i < 30 * BIT; i++) begin
                @(negedge hw_clk);
                if (!rx_busy) busy_lo++;
            end
        join
        step(BIT);
        rx_ready = 1'b0;
        chk("b2b accept count", acc_q.size(), 3);
        chk("b2b byte0", acc_q.size() > 0 ? int'(acc_q[0]) : -1, 8'h00);
        chk("b2b byte1", acc_q.size() > 1 ? int'(acc_q[1]) : -1, 8'hFF);
        chk("b2b byte2", acc_q.size() > 2 ? int'(acc_q[2]) : -1, 8'h55);
        chk("b2b rx_busy low cycles", busy_lo, 96);

        clr();
        align();
        busy_seen = 0;
        for (int i = 0; i < 100; i++) begin
            uartrx = i < 20 ? 1'b0 : 1'b1;
            step();
            if (rx_busy) busy_seen = 1;
        end
        chk("glitch start detected", busy_seen, 1);
        chk("glitch rx_busy", rx_busy, 0);
        chk("glitch rx_valid", rx_valid, 0);
        chk("glitch frame_err pulses", ferr_n, 0);

        clr();
        align();
        send(8'h3C, 1'b0);
        step(2000);
        uartrx = 1'b1;
        step(BIT);
        chk("break frame_err pulses", ferr_n, 1);
        chk("break rx_valid", rx_valid, 0);
        chk("break rx_busy", rx_busy, 0);
        clr();
        align();
        send(8'h81, 1'b1);
        step(BIT);
        chk("post-break rx_valid", rx_valid, 1);
        chk("post-break rx_data", rx_data, 8'h81);
        chk("post-break frame_err pulses", ferr_n, 0);
        drain();

        clr();
        align();
        send(8'h11, 1'b1);
        step(BIT);
        align();
        s = cyc;
        send(8'h22, 1'b1);
        step(BIT);
        chk("overrun pulses", ovr_n, 1);
        chk("overrun held rx_data", rx_data, 8'h11);
        d = ovr_cyc - s;
        if (d < 2) d = 2;
        clr();
        align();
        fork
            send(8'h33, 1'b1);
            begin
                step(d - 1);
                rx_ready = 1'b1;
                step();
                rx_ready = 1'b0;
            end
        join
        step(BIT);
        chk("simul overrun pulses", ovr_n, 0);
        chk("simul rx_valid", rx_valid, 1);
        chk("simul rx_data", rx_data, 8'h33);
        chk("simul accepted old byte", acc_q.size() == 1 ? int'(acc_q[0]) : -1, 8'h11);

        clr();
        align();
        fork
            send(8'hC3, 1'b1);
            begin
                step(4 * BIT + 30);
                rst_n = 1'b0;
                #1;
                chk("mid reset rx_valid", rx_valid, 0);
                chk("mid reset rx_data", rx_data, 0);
                chk("mid reset rx_busy", rx_busy, 0);
                chk("mid reset frame_err", frame_err, 0);
                chk("mid reset overrun", overrun, 0);
                step(3);
                rst_n = 1'b1;
            end
        join
        uartrx = 1'b1;
        step(600);
        drain();
        step(BIT);
        clr();
        align();
        send(8'h5A, 1'b1);
        step(BIT);
        chk("post-reset rx_valid", rx_valid, 1);
        chk("post-reset rx_data", rx_data, 8'h5A);
        chk("post-reset frame_err pulses", ferr_n, 0);
        chk("post-reset overrun pulses", ovr_n, 0);
        drain();

        for (int m = 0; m < 2; m++) begin
            clr();
            exp_q.delete();
            rx_ready = m == 0;
            nbad = 0;
            ngood = 0;
            first = 8'h00;
            for (int k = 0; k < 10; k++) begin
                b = 8'($urandom);
                st = $urandom_range(0, 3) != 0;
                send(b, st);
                uartrx = 1'b1;
                step(st ? $urandom_range(0, 40) : $urandom_range(16, 60));
                if (st) begin
                    if (ngood == 0) first = b;
                    ngood++;
                    exp_q.push_back(b);
                end else begin
                    nbad++;
                end
            end
            step(BIT);
            rx_ready = 1'b0;
            chk($sformatf("rand%0d frame_err pulses", m), ferr_n, nbad);
            if (m == 0) begin
                chk("rand0 accept count", acc_q.size(), ngood);
                chk("rand0 overrun pulses", ovr_n, 0);
                for (int j = 0; j < exp_q.size(); j++)
                    chk($sformatf("rand0 byte%0d", j), j < acc_q.size() ? int'(acc_q[j]) : -1, exp_q[j]);
            end else begin
                chk("rand1 overrun pulses", ovr_n, ngood > 0 ? ngood - 1 : 0);
                chk("rand1 rx_valid", rx_valid, ngood > 0 ? 1 : 0);
                if (ngood > 0) chk("rand1 held byte", rx_data, first);
                drain();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
